hazard_scoreboard: RTL and testbench

Hazard responder for the 5-stage pipeline: consumes the source/destination information the decode stage exports and returns the `freeze` and `flush` controls that decode and fetch obey. It keeps a shadow copy of the destination fields of the instructions in EXE and MEM, compares them against the decoding instruction's sources, and raises `freeze` on a RAW hazard. It also converts a taken branch into `flush`, and keeps saturating stall and flush statistics.

---
 rtl/hazard_scoreboard.sv | 91 +++++++++
 tb/tb_hazard_scoreboard.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// RAW hazard responder: shadows EXE/MEM destination fields and produces
// freeze/flush for decode and fetch, plus saturating stall/flush statistics.
module hazard_scoreboard #(
    parameter int FORWARD_EN = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_uses_src2,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic [4:0]       id_dest,
    input  logic             exe_branch_taken,
    output logic             freeze,
    output logic             flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic       v;
        logic       wb;
        logic       ld;
        logic [4:0] dest;
    } ent_t;

    ent_t             r_ex;
    ent_t             r_mem;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_hz1;
    logic             w_hz2;
    logic             w_freeze;
    logic             w_flush;
    ent_t             w_ex_nxt;

    // Register 0 is hardwired, so it can never be a true dependency.
    function automatic logic f_match(input ent_t e, input logic [4:0] s);
        return e.v & e.wb & (e.dest == s) & (s != 5'd0);
    endfunction

    generate
        if (FORWARD_EN != 0) begin : g_fwd
            // With forwarding only a load still in EXE cannot supply its result in time.
            assign w_hz1 = f_match(r_ex, id_src1) & r_ex.ld;
            assign w_hz2 = f_match(r_ex, id_src2) & r_ex.ld;
        end else begin : g_nofwd
            assign w_hz1 = f_match(r_ex, id_src1) | f_match(r_mem, id_src1);
            assign w_hz2 = f_match(r_ex, id_src2) | f_match(r_mem, id_src2);
        end
    endgenerate

    assign w_flush  = exe_branch_taken;
    assign w_freeze = id_valid & ~w_flush & (w_hz1 | (id_uses_src2 & w_hz2));

    always_comb begin
        w_ex_nxt = '0;
        if (!w_freeze && !w_flush) begin
            w_ex_nxt.v    = id_valid;
            w_ex_nxt.wb   = id_wb_en;
            w_ex_nxt.ld   = id_mem_read;
            w_ex_nxt.dest = id_dest;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_mem <= r_ex;
            r_ex  <= w_ex_nxt;
            if (w_freeze && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign freeze      = w_freeze;
    assign flush       = w_flush;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: u0 has no forwarding (3-bit counters for saturation),
// u1 has forwarding; both see the same decode stream.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_src1;
    logic [4:0]  id_src2;
    logic        id_uses_src2;
    logic        id_wb_en;
    logic        id_mem_read;
    logic [4:0]  id_dest;
    logic        br;
    logic        f0, f1, fl0, fl1;
    logic [2:0]  sc0, fc0;
    logic [15:0] sc1, fc1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.FORWARD_EN(0), .CNT_W(3)) u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src2(id_uses_src2), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .id_dest(id_dest), .exe_branch_taken(br), .freeze(f0), .flush(fl0),
        .stall_count(sc0), .flush_count(fc0)
    );

    hazard_scoreboard #(.FORWARD_EN(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src2(id_uses_src2), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .id_dest(id_dest), .exe_branch_taken(br), .freeze(f1), .flush(fl1),
        .stall_count(sc1), .flush_count(fc1)
    );

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic u2, input logic wb, input logic ld, input logic [4:0] d);
        id_valid = v; id_src1 = s1; id_src2 = s2; id_uses_src2 = u2;
        id_wb_en = wb; id_mem_read = ld; id_dest = d;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; br = 1'b1;
        drive(1, 3, 3, 1, 1, 0, 3);
        #12;
        n_vec++; if (f0 !== 1'b0 || f1 !== 1'b0) begin n_err++; $display("FAIL reset_freeze got %b/%b exp 0/0", f0, f1); end
        n_vec++; if (fl0 !== 1'b1 || fl1 !== 1'b1) begin n_err++; $display("FAIL reset_flush got %b/%b exp 1/1", fl0, fl1); end
        n_vec++; if (sc0 !== 3'd0 || fc0 !== 3'd0 || sc1 !== 16'd0 || fc1 !== 16'd0) begin
            n_err++; $display("FAIL reset_counts got %0d %0d %0d %0d exp 0", sc0, fc0, sc1, fc1); end
        br = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // ADD r3 ; ADD r5,r3,r1
    task automatic test_back_to_back();
        drive(1, 1, 2, 1, 1, 0, 3);
        @(negedge clk);
        n_vec++; if (f0 !== 1'b0) begin n_err++; $display("FAIL b2b_prod f0 got %b exp 0", f0); end
        tick();
        drive(1, 3, 1, 1, 1, 0, 5);
        @(negedge clk);
        n_vec++; if (f0 !== 1'b1 || f1 !== 1'b0) begin n_err++; $display("FAIL b2b_c1 got %b/%b exp 1/0", f0, f1); end
        tick();
        @(negedge clk);
        n_vec++; if (f0 !== 1'b1) begin n_err++; $display("FAIL b2b_c2 f0 got %b exp 1", f0); end
        tick();
        @(negedge clk);
        n_vec++; if (f0 !== 1'b0) begin n_err++; $display("FAIL b2b_c3 f0 got %b exp 0", f0); end
        n_vec++; if (sc0 !== 3'd2 || sc1 !== 16'd0) begin n_err++; $display("FAIL b2b_stalls got %0d/%0d exp 2/0", sc0, sc1); end
        tick();
        drain();
    endtask

    // ADD r3 ; NOP ; consumer of r3
    task automatic test_mem_dep();
        drive(1, 1, 2, 1, 1, 0, 3);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 3, 0, 0, 1, 0, 8);
        @(negedge clk);
        n_vec++; if (f0 !== 1'b1 || f1 !== 1'b0) begin n_err++; $display("FAIL memdep_c1 got %b/%b exp 1/0", f0, f1); end
        tick();
        @(negedge clk);
        n_vec++; if (f0 !== 1'b0) begin n_err++; $display("FAIL memdep_c2 f0 got %b exp 0", f0); end
        n_vec++; if (sc0 !== 3'd3) begin n_err++; $display("FAIL memdep_stalls got %0d exp 3", sc0); end
        tick();
        drain();
    endtask

    // LD r4 ; ADD r6,r4,r2
    task automatic test_load_use();
        drive(1, 1, 2, 1, 1, 1, 4);
        tick();
        drive(1, 4, 2, 1, 1, 0, 6);
        @(negedge clk);
        n_vec++; if (f0 !== 1'b1 || f1 !== 1'b1) begin n_err++; $display("FAIL ldu_c1 got %b/%b exp 1/1", f0, f1); end
        tick();
        @(negedge clk);
        n_vec++; if (f0 !== 1'b1 || f1 !== 1'b0) begin n_err++; $display("FAIL ldu_c2 got %b/%b exp 1/0", f0, f1); end
        tick();
        @(negedge clk);
        n_vec++; if (f0 !== 1'b0) begin n_err++; $display("FAIL ldu_c3 f0 got %b exp 0", f0); end
        n_vec++; if (sc0 !== 3'd5 || sc1 !== 16'd1) begin n_err++; $display("FAIL ldu_stalls got %0d/%0d exp 5/1", sc0, sc1); end
        tick();
        drain();
    endtask

    task automatic test_r0_and_store();
        drive(1, 1, 2, 1, 1, 1, 0);
        tick();
        drive(1, 0, 0, 1, 1, 0, 9);
        @(negedge clk);
        n_vec++; if (f0 !== 1'b0 || f1 !== 1'b0) begin n_err++; $display("FAIL r0 got %b/%b exp 0/0", f0, f1); end
        tick();
        drain();
        drive(1, 1, 2, 1, 1, 0, 7);
        tick();
        drive(1, 1, 7, 1, 0, 0, 0);
        #2;
        n_vec++; if (f0 !== 1'b1) begin n_err++; $display("FAIL st_rt_used f0 got %b exp 1", f0); end
        id_uses_src2 = 1'b0;
        #2;
        n_vec++; if (f0 !== 1'b0) begin n_err++; $display("FAIL st_rt_unused f0 got %b exp 0", f0); end
        tick();
        n_vec++; if (sc0 !== 3'd5) begin n_err++; $display("FAIL st_stalls got %0d exp 5", sc0); end
        drain();
    endtask

    // ADD r3 ; X(src r3, dest r9) flushed ; consumer of r9 must not stall
    task automatic test_flush();
        drive(1, 1, 2, 1, 1, 1, 3);
        tick();
        drive(1, 3, 0, 0, 1, 1, 9);
        br = 1'b1;
        @(negedge clk);
        n_vec++; if (fl0 !== 1'b1 || fl1 !== 1'b1) begin n_err++; $display("FAIL flush_out got %b/%b exp 1/1", fl0, fl1); end
        n_vec++; if (f0 !== 1'b0 || f1 !== 1'b0) begin n_err++; $display("FAIL flush_freeze got %b/%b exp 0/0", f0, f1); end
        tick();
        br = 1'b0;
        drive(1, 9, 0, 0, 1, 0, 10);
        @(negedge clk);
        n_vec++; if (f0 !== 1'b0 || f1 !== 1'b0) begin n_err++; $display("FAIL flush_bubble got %b/%b exp 0/0", f0, f1); end
        n_vec++; if (fl0 !== 1'b0) begin n_err++; $display("FAIL flush_drop got %b exp 0", fl0); end
        n_vec++; if (fc0 !== 3'd1 || fc1 !== 16'd1) begin n_err++; $display("FAIL flush_count got %0d/%0d exp 1/1", fc0, fc1); end
        tick();
        drain();
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 1, 2, 1, 1, 0, 3);
        tick();
        drive(1, 3, 0, 0, 1, 0, 11);
        @(negedge clk);
        n_vec++; if (f0 !== 1'b1) begin n_err++; $display("FAIL rstmid_pre f0 got %b exp 1", f0); end
        #1 rst = 1'b1;
        #1;
        n_vec++; if (f0 !== 1'b0) begin n_err++; $display("FAIL rstmid_freeze f0 got %b exp 0", f0); end
        n_vec++; if (sc0 !== 3'd0 || fc0 !== 3'd0 || sc1 !== 16'd0 || fc1 !== 16'd0) begin
            n_err++; $display("FAIL rstmid_counts got %0d %0d %0d %0d exp 0", sc0, fc0, sc1, fc1); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_vec++; if (f0 !== 1'b0 || f1 !== 1'b0) begin n_err++; $display("FAIL rstmid_post got %b/%b exp 0/0", f0, f1); end
        tick();
        drain();
        n_vec++; if (sc0 !== 3'd0) begin n_err++; $display("FAIL rstmid_stalls got %0d exp 0", sc0); end
    endtask

    // Five 2-cycle stalls on a 3-bit counter: holds at 7, freeze unaffected.
    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 2, 1, 1, 0, 3);
            tick();
            drive(1, 3, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (i == 4) begin
                n_vec++; if (f0 !== 1'b1) begin n_err++; $display("FAIL sat_freeze f0 got %b exp 1", f0); end
            end
            tick(); tick(); tick();
        end
        n_vec++; if (sc0 !== 3'd7) begin n_err++; $display("FAIL sat_count got %0d exp 7", sc0); end
        drain();
    endtask

    initial begin
        br = 1'b0;
        test_reset();
        test_back_to_back();
        test_mem_dep();
        test_load_use();
        test_r0_and_store();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
